// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults, types and helpers for the register bank
// with write scoreboard (reg_bank_sb, reg_scoreboard).
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   reg_addr_t / xlen_t  : address and data types at the default sizes
//   popcount()           : population count used for the pending counter
package reg_bank_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  // Widest pending vector popcount() accepts; callers zero-extend into it.
  localparam int unsigned PC_MAXW   = 256;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

  function automatic int unsigned popcount(input logic [PC_MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < PC_MAXW; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write tracker.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   we_i, wa_i        : writeback enable / address (clears pending mark)
//   iss_valid_i       : decode issues a write to iss_rd_i
//   iss_rd_i          : destination register of the issued instruction
//   flush_i           : drop every pending mark
//   pend_o            : pending vector, bit 0 always 0
//   iss_ready_o       : issue accepted this cycle (no WAW hazard)
//   pend_cnt_o        : registered number of pending registers
module reg_scoreboard
  import reg_bank_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic             iss_valid_i,
  input  logic [AW-1:0]    iss_rd_i,
  input  logic             flush_i,
  output logic [NREGS-1:0] pend_o,
  output logic             iss_ready_o,
  output logic [AW:0]      pend_cnt_o
);

  logic [NREGS-1:0]   pend_q, pend_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               wr_clr;
  logic               iss_set;
  logic [PC_MAXW-1:0] pend_ext;

  always_comb begin
    wr_clr      = we_i && (wa_i != '0);
    // A pending destination is released by a writeback landing this cycle.
    iss_ready_o = !pend_q[iss_rd_i] || (we_i && (wa_i == iss_rd_i));
    iss_set     = iss_valid_i && iss_ready_o && (iss_rd_i != '0);

    // Clear before set so a same-register issue (younger) wins; flush last.
    pend_d = pend_q;
    if (wr_clr)  pend_d[wa_i]     = 1'b0;
    if (iss_set) pend_d[iss_rd_i] = 1'b1;
    if (flush_i) pend_d           = '0;
    pend_d[0] = 1'b0;

    pend_ext              = '0;
    pend_ext[NREGS-1:0]   = pend_d;
    cnt_d                 = (AW+1)'(popcount(pend_ext));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o     = pend_q;
  assign pend_cnt_o = cnt_q;

endmodule

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: parametrised register bank, register 0 hard-wired to zero,
// NRD combinational read ports and a pending-write scoreboard.
//   clk, rst       : clock, synchronous active-high reset
//   we, wa, wd     : writeback port
//   ra / rd        : packed read addresses / data, port i at slice i
//   rbusy          : read port i source register has a pending write
//   iss_valid, iss_rd, iss_ready : decode issue handshake
//   flush          : discard all pending marks
//   pend_cnt       : number of registers marked pending
// Build option: REG_BANK_SB_BYPASS_EN forwards the same-cycle writeback
// to matching read ports (rd = wd, rbusy = 0).
module reg_bank_sb
  import reg_bank_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NRD   = 2,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              flush,
  output logic [AW:0]       pend_cnt
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] pend;
  logic [AW-1:0]    rsel;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem_q[wa] <= wd;
    end
  end

  always_comb begin
    rd    = '0;
    rbusy = '0;
    rsel  = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rsel = ra[i*AW +: AW];
      if (rsel != '0) begin
        rd[i*XLEN +: XLEN] = mem_q[rsel];
      end
      rbusy[i] = pend[rsel];
`ifdef REG_BANK_SB_BYPASS_EN
      if (we && (wa != '0) && (rsel == wa)) begin
        rd[i*XLEN +: XLEN] = wd;
        rbusy[i]           = 1'b0;
      end
`endif
    end
  end

  reg_scoreboard #(
    .NREGS(NREGS)
  ) u_sb (
    .clk_i       (clk),
    .rst_i       (rst),
    .we_i        (we),
    .wa_i        (wa),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .flush_i     (flush),
    .pend_o      (pend),
    .iss_ready_o (iss_ready),
    .pend_cnt_o  (pend_cnt)
  );

endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
- Parametrised successor to the core's single-write register bank: configurable data width, register count and number of combinational read ports.
- Register 0 is hard-wired to zero.
- Adds a per-register pending-write scoreboard so the decode stage can detect RAW/WAW hazards against in-flight writebacks.
- Sits between decode (issue side) and writeback (write side) of the pipelined datapath.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >= 2); AW = $clog2(NREGS) is a derived localparam.
- NRD, 2, number of independent read ports (1..4).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  writeback enable.
- wa  in  AW  writeback register address.
- wd  in  XLEN  writeback data.
- ra  in  NRD*AW  packed read addresses; port i uses ra[i*AW +: AW].
- rd  out  NRD*XLEN  packed read data; port i uses rd[i*XLEN +: XLEN].
- rbusy  out  NRD  port i source register has a pending (unwritten) result.
- iss_valid  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  AW  destination register of issued instruction.
- iss_ready  out  1  issue accepted this cycle (no WAW hazard).
- flush  in  1  pipeline flush; discards all pending marks.
- pend_cnt  out  AW+1  number of registers currently marked pending.

Behaviour:
- Reset: rst sampled high at a rising edge of clk clears all NREGS registers and all pend bits in that cycle.
  - Outputs after that edge: rd = 0, rbusy = 0, pend_cnt = 0, iss_ready = 1.
  - rst overrides we, iss_valid and flush in the same cycle.
- Write: at the rising edge with we=1 and wa!=0, mem[wa] <= wd.
  - Writes to address 0 are dropped; mem[0] stays 0 permanently.
- Read: combinational, zero latency.
  - rd_i = 0 when ra_i==0, else mem[ra_i].
  - All NRD ports are independent; any two may alias the same address.
- Scoreboard: pend[NREGS] flops; pend[0] is constant 0.
  - Set: issue accepted (iss_valid && iss_ready) with iss_rd!=0 sets pend[iss_rd] at the clock edge.
  - Clear: we=1 with wa!=0 clears pend[wa] at the clock edge.
  - Set and clear on the same register in the same cycle: set wins (the new issue is younger than the retiring write).
  - Set and clear on different registers in the same cycle: both take effect.
- Issue handshake: iss_ready = !pend[iss_rd] || (we && wa==iss_rd).
  - A pending destination is freed the cycle its writeback arrives.
  - iss_rd==0 is always ready and never marks pending.
  - iss_valid with iss_ready=0 has no effect; decode holds and retries.
- flush=1 clears every pend bit at the edge.
  - flush takes priority over a same-cycle set.
  - The same-cycle register write (we) still completes.
- rbusy_i = pend[ra_i], subject to the bypass rule under Optional Feature.
- pend_cnt is a registered population count of pend, updated in the same edge as pend.
  - Never exceeds NREGS-1.

Optional Feature:
- Macro: REG_BANK_SB_BYPASS_EN.
- Defined:
  - Write-to-read forwarding: when we=1, wa!=0 and ra_i==wa, rd_i = wd (combinational) and rbusy_i = 0 in that cycle.
  - Adds one comparator and mux per read port.
- Undefined:
  - rd_i returns the pre-write mem[ra_i].
  - rbusy_i stays 1 until the cycle after the writeback edge.
  - Decode must stall one extra cycle.

Decomposition:
- Shared package reg_bank_pkg:
  - default XLEN/NREGS constants.
  - typedef reg_addr_t (logic [AW-1:0]) and typedef xlen_t.
  - function popcount used for pend_cnt.
- One sub-module, reg_scoreboard: owns pend, the set/clear/flush priority, iss_ready and pend_cnt.
- Storage and read/bypass muxing stay in the top module.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then ra={5,0} -> rd={0,0}, rbusy=0, pend_cnt=0, iss_ready=1.
- Write/read and x0: we=1, wa=5, wd=0xDEADBEEF, then wa=0, wd=0xFFFFFFFF.
  - Next cycle ra={5,0} -> rd={0xDEADBEEF,0}.
- Scoreboard lifecycle:
  - Issue iss_rd=7 -> pend_cnt=1; ra0=7 gives rbusy[0]=1.
  - Re-issue iss_rd=7 -> iss_ready=0, pend_cnt stays 1.
  - Writeback wa=7, wd=0x12 -> pend_cnt=0 next cycle.
  - Bypass build: rbusy[0]=0 and rd0=0x12 in the writeback cycle. Non-bypass build: both only the cycle after.
- Same-cycle set/clear: pend[3]=1, then we=1, wa=3 together with iss_valid=1, iss_rd=3.
  - iss_ready=1; pend[3] stays 1; pend_cnt unchanged (1).
- Flush vs issue: pend set on regs 1, 2, 4; assert flush with iss_valid, iss_rd=9 and we, wa=2, wd=0x55.
  - Next cycle pend_cnt=0 and rbusy all 0.
  - mem[2]=0x55.
- Reset mid-operation: pend on regs 1..6 and mem[6]=0xA5, assert rst together with we=1, wa=6, wd=0x77.
  - Next cycle mem[6]=0 and pend_cnt=0.
